// File: rtl/uart_pkg.sv
// Shared constants and types for the UART baud tick generator.
package uart_pkg;

  localparam logic BAUD_MODE_TX = 1'b0;
  localparam logic BAUD_MODE_RX = 1'b1;

  localparam int DEFAULT_DIV_9600 = 5208;
  localparam int MIN_DIV          = 2;

  typedef enum logic {IDLE, RUN} baud_state_e;

endpackage

// File: rtl/uart_baud_gen_if.sv
// Control/status bundle between the TX/RX shift FSMs (master) and the baud generator (slave).
// Optional div_frac lane is present only when UART_BAUD_FRAC_DIV_EN is defined.
interface uart_baud_gen_if #(
  parameter int DIV_W = 16
`ifdef UART_BAUD_FRAC_DIV_EN
  , parameter int FRAC_W = 4
`endif
);
  // Handshake: baud_enable is a level run request. div_load is a one-cycle
  // valid strobe qualifying div_value (and div_frac); there is no ready, every
  // strobe is accepted and div_pending stays high until the value takes effect.
  logic             baud_enable;
  logic             mode;
  logic [DIV_W-1:0] div_value;
  logic             div_load;
`ifdef UART_BAUD_FRAC_DIV_EN
  logic [FRAC_W-1:0] div_frac;
`endif
  logic             clk_baud;
  logic             div_pending;
  logic             running;

  modport master (
    output baud_enable, mode, div_value, div_load,
`ifdef UART_BAUD_FRAC_DIV_EN
    output div_frac,
`endif
    input  clk_baud, div_pending, running
  );

  modport slave (
    input  baud_enable, mode, div_value, div_load,
`ifdef UART_BAUD_FRAC_DIV_EN
    input  div_frac,
`endif
    output clk_baud, div_pending, running
  );

endinterface

// File: rtl/uart_baud_frac_acc.sv
// Fractional-divisor phase accumulator; exists only when UART_BAUD_FRAC_DIV_EN is defined.
// extend requests a one-cycle-longer period when the tick being generated carries out.
`ifdef UART_BAUD_FRAC_DIV_EN
module uart_baud_frac_acc #(
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              tick,
  input  logic [FRAC_W-1:0] frac,
  output logic              extend
);

  logic [FRAC_W-1:0] acc_q;
  logic [FRAC_W:0]   sum;

  assign sum    = {1'b0, acc_q} + {1'b0, frac};
  assign extend = sum[FRAC_W];

  // A start tick out of IDLE must accumulate even though IDLE also clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else if (tick) begin
      acc_q <= sum[FRAC_W-1:0];
    end else if (clear) begin
      acc_q <= '0;
    end
  end

endmodule
`endif

// File: rtl/uart_baud_gen.sv
// Programmable baud tick generator for the UART TX/RX shift FSMs (TX phase or mid-bit RX phase).
// Optional fractional divisor is enabled by defining UART_BAUD_FRAC_DIV_EN.
module uart_baud_gen #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = uart_pkg::DEFAULT_DIV_9600,
  parameter int MIN_DIV     = uart_pkg::MIN_DIV
`ifdef UART_BAUD_FRAC_DIV_EN
  , parameter int FRAC_W    = 4
`endif
) (
  input  logic            clk,
  input  logic            reset,
  uart_baud_gen_if.slave  bus
);

  import uart_pkg::baud_state_e;
  import uart_pkg::IDLE;
  import uart_pkg::RUN;
  import uart_pkg::BAUD_MODE_TX;
  import uart_pkg::BAUD_MODE_RX;

  localparam logic [DIV_W-1:0] DEF_D = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] MIN_D = DIV_W'(MIN_DIV);

  baud_state_e      state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pending_q, pending_d;
  logic             applied_q, applied_d;
  logic             tick_q, tick_d;
  logic             apply;
  logic             extend;
  logic [DIV_W-1:0] eff_div;
  logic [DIV_W-1:0] load_val;

  // A pending divisor is what the next period will use, so reloads look through it.
  assign eff_div  = pending_q ? pend_q : div_q;
  assign load_val = (bus.div_value < MIN_D) ? MIN_D : bus.div_value;

  always_comb begin
    state_d   = state_q;
    tick_d    = 1'b0;
    cnt_d     = cnt_q;
    div_d     = div_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    applied_d = 1'b0;
    apply     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        apply = pending_q;
        if (bus.baud_enable) begin
          state_d = RUN;
          case (bus.mode)
            BAUD_MODE_TX: begin
              tick_d = 1'b1;
              cnt_d  = eff_div - DIV_W'(1) + DIV_W'(extend);
            end
            BAUD_MODE_RX: cnt_d = (eff_div >> 1) - DIV_W'(1);
          endcase
        end
      end
      RUN: begin
        if (!bus.baud_enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          tick_d    = 1'b1;
          cnt_d     = eff_div - DIV_W'(1) + DIV_W'(extend);
          apply     = pending_q;
          applied_d = pending_q;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
    endcase
    if (apply) div_d = pend_q;
    if (apply && (state_q == IDLE)) pending_d = 1'b0;
    // In RUN the flag drops at the end of the tick cycle that consumed the value.
    if (applied_q) pending_d = 1'b0;
    if (bus.div_load) begin
      pend_d    = load_val;
      pending_d = 1'b1;
      applied_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= DEF_D;
      pend_q    <= DEF_D;
      pending_q <= 1'b0;
      applied_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      applied_q <= applied_d;
      tick_q    <= tick_d;
    end
  end

`ifdef UART_BAUD_FRAC_DIV_EN
  logic [FRAC_W-1:0] frac_q, pend_frac_q, eff_frac;
  logic              acc_tick, acc_clear;

  assign eff_frac  = pending_q ? pend_frac_q : frac_q;
  assign acc_tick  = bus.baud_enable &&
                     (((state_q == IDLE) && (bus.mode == BAUD_MODE_TX)) ||
                      ((state_q == RUN) && (cnt_q == '0)));
  assign acc_clear = (state_q == IDLE) || !bus.baud_enable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frac_q      <= '0;
      pend_frac_q <= '0;
    end else begin
      if (apply)        frac_q      <= pend_frac_q;
      if (bus.div_load) pend_frac_q <= bus.div_frac;
    end
  end

  uart_baud_frac_acc #(.FRAC_W(FRAC_W)) u_frac_acc (
    .clk    (clk),
    .reset  (reset),
    .clear  (acc_clear),
    .tick   (acc_tick),
    .frac   (eff_frac),
    .extend (extend)
  );
`else
  assign extend = 1'b0;
`endif

  assign bus.clk_baud    = tick_q;
  assign bus.div_pending = pending_q;
  assign bus.running     = (state_q == RUN);

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen: table of divisor/mode runs plus hand-written
// sequences for live divisor change, disable/re-enable and asynchronous reset.
module tb_uart_baud_gen;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  uart_baud_gen_if #(.DIV_W(16)) bus();

  uart_baud_gen #(.DIV_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] div;
    logic        mode;
    int          run_len;
    int          exp_first;
    int          exp_period;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input int t, input int p, input int r);
    chk({name, "_tick"}, int'(bus.clk_baud), t);
    chk({name, "_pend"}, int'(bus.div_pending), p);
    chk({name, "_run"}, int'(bus.running), r);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic load_idle(input logic [15:0] d);
    bus.div_value = d;
    bus.div_load  = 1'b1;
    step();
    bus.div_load  = 1'b0;
    chk("idle_load_pend", int'(bus.div_pending), 1);
    step();
    chk("idle_load_done", int'(bus.div_pending), 0);
  endtask

  // Enable at k=0, drop at k=run_len; mode is flipped mid-run and must be ignored.
  task automatic run_vec(input vec_t v);
    bit exp_t;
    bus.mode = v.mode;
    for (int k = 0; k <= v.run_len + 1; k++) begin
      bus.baud_enable = (k < v.run_len);
      if (k >= 2) bus.mode = ~v.mode;
      exp_t = (k <= v.run_len) && (k >= v.exp_first) &&
              (((k - v.exp_first) % v.exp_period) == 0);
      chk_out("run_vec", int'(exp_t), 0, int'((k >= 1) && (k <= v.run_len)));
      step();
    end
  endtask

  initial begin
    vec_t dflt;
    int   nticks;
    bus.baud_enable = 1'b0;
    bus.mode        = BAUD_MODE_TX;
    bus.div_value   = '0;
    bus.div_load    = 1'b0;
`ifdef UART_BAUD_FRAC_DIV_EN
    bus.div_frac    = '0;
`endif
    vecs[0] = '{16'd8, BAUD_MODE_TX, 24, 1, 8};
    vecs[1] = '{16'd9, BAUD_MODE_RX, 31, 5, 9};
    vecs[2] = '{16'd2, BAUD_MODE_TX, 10, 1, 2};
    vecs[3] = '{16'd2, BAUD_MODE_RX, 9, 2, 2};
    vecs[4] = '{16'd5, BAUD_MODE_RX, 12, 3, 5};
    vecs[5] = '{16'd1, BAUD_MODE_TX, 6, 1, 2};
    vecs[6] = '{16'd0, BAUD_MODE_RX, 7, 2, 2};
    vecs[7] = '{16'd3, BAUD_MODE_RX, 10, 2, 3};
    dflt    = '{16'd5208, BAUD_MODE_TX, 5210, 1, 5208};

    // Reset state
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_out("in_reset", 0, 0, 0);
    reset = 1'b0;
    step();
    chk_out("after_reset", 0, 0, 0);

    // Default divisor: ticks exactly 1 and 1+5208 cycles after enable
    run_vec(dflt);

    foreach (vecs[i]) begin
      load_idle(vecs[i].div);
      run_vec(vecs[i]);
    end

    // Live divisor changes: mid-period, last-write-wins, load in a tick cycle
    load_idle(16'd8);
    bus.mode = BAUD_MODE_TX;
    for (int k = 0; k <= 34; k++) begin
      bus.baud_enable = (k < 33);
      bus.div_load    = (k == 4) || (k == 18) || (k == 19) || (k == 24);
      case (k)
        4:       bus.div_value = 16'd4;
        18:      bus.div_value = 16'd6;
        19:      bus.div_value = 16'd3;
        24:      bus.div_value = 16'd5;
        default: bus.div_value = 16'd0;
      endcase
      chk_out("live_div", int'(k inside {1, 9, 13, 17, 21, 24, 27, 32}),
              int'(k inside {[5:9], [19:21], [25:27]}), int'((k >= 1) && (k <= 33)));
      step();
    end
    bus.div_load = 1'b0;

    // Disable with a tick due, re-enable later and right after a drop
    load_idle(16'd8);
    for (int k = 0; k <= 27; k++) begin
      bus.baud_enable = !(k inside {8, 9, 14}) && (k < 26);
      chk_out("dis_reen", int'(k inside {1, 11, 16, 24}), 0,
              int'((k <= 26) && !(k inside {0, 9, 10, 15})));
      step();
    end

    // Asynchronous reset in a tick cycle with a divisor still pending
    load_idle(16'd20);
    bus.mode = BAUD_MODE_TX;
    for (int k = 0; k <= 21; k++) begin
      bus.baud_enable = 1'b1;
      bus.div_load    = (k == 10);
      bus.div_value   = 16'd7;
      chk_out("pre_rst", int'(k inside {1, 21}), int'(k inside {[11:21]}), int'(k >= 1));
      if (k < 21) step();
    end
    bus.div_load = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_out("async_rst", 0, 0, 0);
    bus.baud_enable = 1'b0;
    step();
    chk_out("rst_hold", 0, 0, 0);
    reset = 1'b0;
    step();
    chk_out("rst_release", 0, 0, 0);
    run_vec(dflt);

`ifdef UART_BAUD_FRAC_DIV_EN
    // D=4 with frac 8/16: periods alternate 4,5
    bus.div_frac = 4'd8;
    load_idle(16'd4);
    bus.mode = BAUD_MODE_TX;
    nticks = 0;
    for (int k = 0; k <= 146; k++) begin
      bus.baud_enable = (k < 145);
      if (k >= 1 && k <= 144 && bus.clk_baud) nticks++;
      if (k <= 145)
        chk("frac_tick", int'(bus.clk_baud),
            int'((k >= 1) && ((((k - 1) % 9) == 0) || (((k - 1) % 9) == 4))));
      step();
    end
    chk("frac_count", nticks, 32);
`else
    nticks = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
